// File: rtl/conv_window_feeder.sv
// conv_window_feeder: buffers a raster-ordered frame and a 9-byte kernel, then
// streams 3x3 windows and the kernel to the 3x3 convolution core.
// Build option: define CONV_FEEDER_PAD_EN for a 5x5 frame with a one-pixel zero
// border ("same" convolution); otherwise the frame is 7x7 ("valid" convolution).
module conv_window_feeder #(
    parameter int PIX_W   = 8,
    parameter int OUT_DIM = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    output logic             pix_ready,
    input  logic             w_valid,
    input  logic [PIX_W-1:0] w_data,
    output logic             w_ready,
    output logic             in_valid,
    output logic [PIX_W-1:0] In_IFM_1,
    output logic [PIX_W-1:0] In_IFM_2,
    output logic [PIX_W-1:0] In_IFM_3,
    output logic [PIX_W-1:0] In_IFM_4,
    output logic [PIX_W-1:0] In_IFM_5,
    output logic [PIX_W-1:0] In_IFM_6,
    output logic [PIX_W-1:0] In_IFM_7,
    output logic [PIX_W-1:0] In_IFM_8,
    output logic [PIX_W-1:0] In_IFM_9,
    output logic             weight_valid,
    output logic [PIX_W-1:0] In_Weight_1,
    output logic [PIX_W-1:0] In_Weight_2,
    output logic [PIX_W-1:0] In_Weight_3,
    output logic [PIX_W-1:0] In_Weight_4,
    output logic [PIX_W-1:0] In_Weight_5,
    output logic [PIX_W-1:0] In_Weight_6,
    output logic [PIX_W-1:0] In_Weight_7,
    output logic [PIX_W-1:0] In_Weight_8,
    output logic [PIX_W-1:0] In_Weight_9,
    output logic             frame_done
);

`ifdef CONV_FEEDER_PAD_EN
    localparam int IN_DIM = OUT_DIM;
    localparam int PAD    = 1;
`else
    localparam int IN_DIM = OUT_DIM + 2;
    localparam int PAD    = 0;
`endif
    localparam int NPIX = IN_DIM * IN_DIM;
    localparam int NWIN = OUT_DIM * OUT_DIM;
    localparam int PCW  = $clog2(NPIX);
    localparam int RCW  = $clog2(OUT_DIM + 1);

    localparam logic [PCW-1:0] PIX_LAST = PCW'(NPIX - 1);
    localparam logic [RCW-1:0] IDX_LAST = RCW'(OUT_DIM - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StWaitW, StSend} state_e;

    state_e           state_q, state_d;
    logic [PCW-1:0]   pix_cnt_q;
    logic [3:0]       w_cnt_q;
    logic             w_loaded_q;
    logic [RCW-1:0]   win_r_q, win_r_d, win_c_q, win_c_d;
    logic             in_valid_q, in_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             weight_valid_q;
    logic             go_send, load_win;
    logic [PIX_W-1:0] frame_q [NPIX];
    logic [PIX_W-1:0] w_sr_q  [8];
    logic [PIX_W-1:0] wgt_q   [9];
    logic [PIX_W-1:0] ifm_q   [9];
    logic [PIX_W-1:0] tap_d   [9];

    logic pix_acc, w_acc, pix_last, w_last, win_last;

    assign pix_ready = (state_q == StIdle) || (state_q == StLoad);
    assign w_ready   = (state_q != StSend);
    assign pix_acc   = pix_valid && pix_ready;
    assign w_acc     = w_valid && w_ready;
    assign pix_last  = (pix_cnt_q == PIX_LAST);
    assign w_last    = w_acc && (w_cnt_q == 4'd8);
    assign win_last  = (win_r_q == IDX_LAST) && (win_c_q == IDX_LAST);

    // Next state, window sequencing and the registered valid/done strobes
    always_comb begin
        state_d      = state_q;
        go_send      = 1'b0;
        load_win     = 1'b0;
        in_valid_d   = 1'b0;
        frame_done_d = 1'b0;
        win_r_d      = win_r_q;
        win_c_d      = win_c_q;
        unique case (state_q)
            StIdle: begin
                if (pix_acc) state_d = StLoad;
            end
            StLoad: begin
                if (pix_acc && pix_last) begin
                    if (w_loaded_q || w_last) go_send = 1'b1;
                    else                      state_d = StWaitW;
                end
            end
            StWaitW: begin
                if (w_last) go_send = 1'b1;
            end
            StSend: begin
                if (win_last) begin
                    state_d = StIdle;
                end else begin
                    load_win   = 1'b1;
                    in_valid_d = 1'b1;
                    if (win_c_q == IDX_LAST) begin
                        win_c_d = '0;
                        win_r_d = win_r_q + 1'b1;
                    end else begin
                        win_c_d = win_c_q + 1'b1;
                    end
                    frame_done_d = (win_r_d == IDX_LAST) && (win_c_d == IDX_LAST);
                end
            end
            default: state_d = StIdle;
        endcase
        // Window 0 is launched on the edge that completes the frame/kernel pair
        if (go_send) begin
            state_d      = StSend;
            load_win     = 1'b1;
            in_valid_d   = 1'b1;
            win_r_d      = '0;
            win_c_d      = '0;
            frame_done_d = (NWIN == 1);
        end
    end

    // Gather the 3x3 taps of the window at (win_r_d, win_c_d); border taps read 0
    always_comb begin
        int row;
        int col;
        for (int a = 0; a < 3; a++) begin
            for (int b = 0; b < 3; b++) begin
                row = int'(win_r_d) + a - PAD;
                col = int'(win_c_d) + b - PAD;
                if (row < 0 || row >= IN_DIM || col < 0 || col >= IN_DIM) begin
                    tap_d[3*a+b] = '0;
                end else begin
                    tap_d[3*a+b] = frame_q[PCW'(row * IN_DIM + col)];
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Window position, window outputs and strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_r_q      <= '0;
            win_c_q      <= '0;
            in_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            for (int k = 0; k < 9; k++) ifm_q[k] <= '0;
        end else begin
            win_r_q      <= win_r_d;
            win_c_q      <= win_c_d;
            in_valid_q   <= in_valid_d;
            frame_done_q <= frame_done_d;
            if (load_win) begin
                for (int k = 0; k < 9; k++) ifm_q[k] <= tap_d[k];
            end
        end
    end

    // Pixel counter; wraps to 0 after the last pixel of a frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_cnt_q <= '0;
        end else if (pix_acc) begin
            pix_cnt_q <= pix_last ? '0 : pix_cnt_q + 1'b1;
        end
    end

    // Frame storage is pure data; the counter reset is enough to discard a partial frame
    always_ff @(posedge clk) begin
        if (pix_acc) frame_q[pix_cnt_q] <= pix_data;
    end

    // Kernel shift register; all nine weights publish together on the 9th byte
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_cnt_q        <= '0;
            w_loaded_q     <= 1'b0;
            weight_valid_q <= 1'b0;
            for (int k = 0; k < 8; k++) w_sr_q[k] <= '0;
            for (int k = 0; k < 9; k++) wgt_q[k] <= '0;
        end else begin
            weight_valid_q <= w_last;
            if (w_acc) begin
                for (int k = 0; k < 7; k++) w_sr_q[k] <= w_sr_q[k+1];
                w_sr_q[7] <= w_data;
                w_cnt_q   <= w_last ? 4'd0 : w_cnt_q + 4'd1;
            end
            if (w_last) begin
                w_loaded_q <= 1'b1;
                for (int k = 0; k < 8; k++) wgt_q[k] <= w_sr_q[k];
                wgt_q[8] <= w_data;
            end
        end
    end

    assign in_valid     = in_valid_q;
    assign frame_done   = frame_done_q;
    assign weight_valid = weight_valid_q;

    assign In_IFM_1 = ifm_q[0];
    assign In_IFM_2 = ifm_q[1];
    assign In_IFM_3 = ifm_q[2];
    assign In_IFM_4 = ifm_q[3];
    assign In_IFM_5 = ifm_q[4];
    assign In_IFM_6 = ifm_q[5];
    assign In_IFM_7 = ifm_q[6];
    assign In_IFM_8 = ifm_q[7];
    assign In_IFM_9 = ifm_q[8];

    assign In_Weight_1 = wgt_q[0];
    assign In_Weight_2 = wgt_q[1];
    assign In_Weight_3 = wgt_q[2];
    assign In_Weight_4 = wgt_q[3];
    assign In_Weight_5 = wgt_q[4];
    assign In_Weight_6 = wgt_q[5];
    assign In_Weight_7 = wgt_q[6];
    assign In_Weight_8 = wgt_q[7];
    assign In_Weight_9 = wgt_q[8];

endmodule

// File: tb/tb_conv_window_feeder.sv
// tb_conv_window_feeder: directed self-checking bench for conv_window_feeder.
// Honours CONV_FEEDER_PAD_EN to select the padded 5x5 frame scenario.
module tb_conv_window_feeder;

`ifdef CONV_FEEDER_PAD_EN
    localparam int IN_DIM = 5;
`else
    localparam int IN_DIM = 7;
`endif
    localparam int NPIX = IN_DIM * IN_DIM;

    logic       clk;
    logic       rst_n;
    logic       pix_valid, pix_ready, w_valid, w_ready;
    logic [7:0] pix_data, w_data;
    logic       in_valid, weight_valid, frame_done;
    logic [7:0] ifm1, ifm2, ifm3, ifm4, ifm5, ifm6, ifm7, ifm8, ifm9;
    logic [7:0] wt1, wt2, wt3, wt4, wt5, wt6, wt7, wt8, wt9;
    logic [71:0] ifm_pk, wgt_pk;

    assign ifm_pk = {ifm1, ifm2, ifm3, ifm4, ifm5, ifm6, ifm7, ifm8, ifm9};
    assign wgt_pk = {wt1, wt2, wt3, wt4, wt5, wt6, wt7, wt8, wt9};

    conv_window_feeder #(.PIX_W(8), .OUT_DIM(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .in_valid(in_valid),
        .In_IFM_1(ifm1), .In_IFM_2(ifm2), .In_IFM_3(ifm3),
        .In_IFM_4(ifm4), .In_IFM_5(ifm5), .In_IFM_6(ifm6),
        .In_IFM_7(ifm7), .In_IFM_8(ifm8), .In_IFM_9(ifm9),
        .weight_valid(weight_valid),
        .In_Weight_1(wt1), .In_Weight_2(wt2), .In_Weight_3(wt3),
        .In_Weight_4(wt4), .In_Weight_5(wt5), .In_Weight_6(wt6),
        .In_Weight_7(wt7), .In_Weight_8(wt8), .In_Weight_9(wt9),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int nwin, first_iv_cyc, last_iv_cyc, fd_cnt, fd_cyc, wv_cnt, wv_cyc, iv_wr;
    logic [71:0] win_log [64];
    int c_last;

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected window from a frame whose pixel j holds (j + off)
    function automatic logic [71:0] win_of(input int r, input int c, input int off);
        logic [71:0] res;
        res = '0;
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++)
                res = {res[63:0], 8'((r + a) * IN_DIM + c + b + off)};
        return res;
    endfunction

    task automatic clear_logs();
        nwin = 0; first_iv_cyc = -1; last_iv_cyc = -1;
        fd_cnt = 0; fd_cyc = -1; wv_cnt = 0; wv_cyc = -1; iv_wr = 0;
    endtask

    // Advance one clock and log what the DUT shows for the new cycle
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (in_valid) begin
            if (nwin < 64) win_log[nwin] = ifm_pk;
            if (nwin == 0) first_iv_cyc = cyc;
            last_iv_cyc = cyc;
            nwin++;
            if (w_ready) iv_wr++;
        end
        if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
        if (weight_valid) begin wv_cnt++; wv_cyc = cyc; end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic send_weights(input int base, input int n);
        for (int k = 0; k < n; k++) begin
            w_valid = 1'b1;
            w_data  = 8'(base + k);
            step();
        end
        w_valid = 1'b0;
    endtask

    task automatic send_pixels(input int off, input int n);
        for (int j = 0; j < n; j++) begin
            pix_valid = 1'b1;
            pix_data  = 8'(j + off);
            step();
        end
        pix_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; pix_valid = 1'b0; pix_data = '0; w_valid = 1'b0; w_data = '0;
        clear_logs();
        steps(2);
        check_eq("rst_in_valid", 72'(in_valid), 72'd0);
        check_eq("rst_weight_valid", 72'(weight_valid), 72'd0);
        check_eq("rst_frame_done", 72'(frame_done), 72'd0);
        check_eq("rst_pix_ready", 72'(pix_ready), 72'd1);
        check_eq("rst_w_ready", 72'(w_ready), 72'd1);
        check_eq("rst_ifm", ifm_pk, 72'd0);
        check_eq("rst_wgt", wgt_pk, 72'd0);
        rst_n = 1'b1;
        step();

`ifdef CONV_FEEDER_PAD_EN
        send_weights(1, 9);
        clear_logs();
        for (int j = 0; j < NPIX; j++) begin
            pix_valid = 1'b1; pix_data = 8'hFF; step();
        end
        pix_valid = 1'b0;
        c_last = cyc;
        steps(30);
        check_eq("pad_nwin", 72'(nwin), 72'd25);
        check_eq("pad_first_iv", 72'(first_iv_cyc), 72'(c_last));
        check_eq("pad_fd_cyc", 72'(fd_cyc), 72'(c_last + 24));
        check_eq("pad_win0", win_log[0], {8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF});
        check_eq("pad_win12", win_log[12], {9{8'hFF}});
        check_eq("pad_win24", win_log[24], {8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00});
        check_eq("pad_wgt", wgt_pk, {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9});
`else
        // Kernel first, then frame
        clear_logs();
        send_weights(1, 9);
        check_eq("k1_wv_pulse", 72'(weight_valid), 72'd1);
        check_eq("k1_wv_cyc", 72'(wv_cyc), 72'(cyc));
        check_eq("k1_wgt", wgt_pk, {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9});
        step();
        check_eq("k1_wv_drop", 72'(weight_valid), 72'd0);
        clear_logs();
        send_pixels(0, NPIX);
        c_last = cyc;
        steps(30);
        check_eq("f1_nwin", 72'(nwin), 72'd25);
        check_eq("f1_first_iv", 72'(first_iv_cyc), 72'(c_last));
        check_eq("f1_no_gap", 72'(last_iv_cyc - first_iv_cyc + 1), 72'd25);
        check_eq("f1_fd_cnt", 72'(fd_cnt), 72'd1);
        check_eq("f1_fd_cyc", 72'(fd_cyc), 72'(c_last + 24));
        check_eq("f1_win0", win_log[0], {8'd0, 8'd1, 8'd2, 8'd7, 8'd8, 8'd9, 8'd14, 8'd15, 8'd16});
        check_eq("f1_win12", win_log[12], {8'd16, 8'd17, 8'd18, 8'd23, 8'd24, 8'd25, 8'd30, 8'd31, 8'd32});
        check_eq("f1_win24", win_log[24], {8'd32, 8'd33, 8'd34, 8'd39, 8'd40, 8'd41, 8'd46, 8'd47, 8'd48});
        check_eq("f1_win7", win_log[7], win_of(1, 2, 0));
        check_eq("f1_no_wv", 72'(wv_cnt), 72'd0);
        check_eq("f1_ifm_hold", ifm_pk, win_of(4, 4, 0));

        // Frame before kernel
        pulse_reset();
        clear_logs();
        send_pixels(100, NPIX);
        steps(10);
        check_eq("f2_pix_ready_waitw", 72'(pix_ready), 72'd0);
        check_eq("f2_no_iv_yet", 72'(nwin), 72'd0);
        send_weights(11, 9);
        c_last = cyc;
        check_eq("f2_wv_with_iv", {70'd0, weight_valid, in_valid}, 72'b11);
        check_eq("f2_wgt", wgt_pk, {8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18, 8'd19});
        check_eq("f2_win0", ifm_pk, win_of(0, 0, 100));
        steps(30);
        check_eq("f2_nwin", 72'(nwin), 72'd25);
        check_eq("f2_fd_cyc", 72'(fd_cyc), 72'(c_last + 24));
        check_eq("f2_win24", win_log[24], win_of(4, 4, 100));

        // Back-pressure on the kernel port during SEND
        clear_logs();
        send_pixels(0, NPIX);
        c_last = cyc;
        w_valid = 1'b1;
        w_data  = 8'hAA;
        check_eq("bp_w_ready_send", 72'(w_ready), 72'd0);
        steps(24);
        check_eq("bp_fd_now", 72'(frame_done), 72'd1);
        check_eq("bp_w_ready_last", 72'(w_ready), 72'd0);
        check_eq("bp_wgt_held", wgt_pk, {8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18, 8'd19});
        step();
        check_eq("bp_w_ready_resume", 72'(w_ready), 72'd1);
        steps(9);
        w_valid = 1'b0;
        check_eq("bp_iv_wr", 72'(iv_wr), 72'd0);
        check_eq("bp_wv_cyc", 72'(wv_cyc), 72'(c_last + 34));
        check_eq("bp_wgt_new", wgt_pk, {9{8'hAA}});
        check_eq("bp_nwin", 72'(nwin), 72'd25);

        // Reset in the middle of SEND
        clear_logs();
        send_pixels(0, NPIX);
        steps(10);
        check_eq("mr_win10", ifm_pk, win_of(2, 0, 0));
        rst_n = 1'b0;
        step();
        check_eq("mr_in_valid", 72'(in_valid), 72'd0);
        check_eq("mr_ifm", ifm_pk, 72'd0);
        check_eq("mr_wgt", wgt_pk, 72'd0);
        check_eq("mr_flags", {69'd0, weight_valid, frame_done, 1'b0}, 72'd0);
        check_eq("mr_pix_ready", 72'(pix_ready), 72'd1);
        rst_n = 1'b1;
        clear_logs();
        send_pixels(50, NPIX);
        steps(10);
        check_eq("mr_need_kernel", 72'(nwin), 72'd0);
        check_eq("mr_waitw", 72'(pix_ready), 72'd0);
        send_weights(1, 9);
        check_eq("mr_iv_after_k", 72'(in_valid), 72'd1);
        check_eq("mr_win0", ifm_pk, win_of(0, 0, 50));
        steps(30);

        // Last pixel and 9th weight in the same cycle
        pulse_reset();
        clear_logs();
        send_weights(21, 8);
        send_pixels(0, NPIX - 1);
        pix_valid = 1'b1; pix_data = 8'(NPIX - 1);
        w_valid = 1'b1; w_data = 8'd29;
        step();
        pix_valid = 1'b0; w_valid = 1'b0;
        c_last = cyc;
        check_eq("sim_both", {70'd0, weight_valid, in_valid}, 72'b11);
        check_eq("sim_wgt", wgt_pk, {8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26, 8'd27, 8'd28, 8'd29});
        check_eq("sim_win0", ifm_pk, win_of(0, 0, 0));
        steps(30);
        check_eq("sim_nwin", 72'(nwin), 72'd25);
        check_eq("sim_fd_cyc", 72'(fd_cyc), 72'(c_last + 24));
        check_eq("sim_win24", win_log[24], win_of(4, 4, 0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_window_feeder.md
# conv_window_feeder

Transmit-side companion of the 3x3 convolution core. It accepts a raster-ordered 8-bit image frame and a serial 9-byte kernel, buffers both, and drives the core's window/weight input protocol. The protocol is `in_valid` plus nine `In_IFM_n`, and `weight_valid` plus nine `In_Weight_n`. Each frame produces 25 consecutive 3x3 windows, one per cycle, which matches the core's fixed 25-output run.

## Interface
Parameters:
- `PIX_W`, 8: pixel and weight width.
- `OUT_DIM`, 5: output map edge. There are `OUT_DIM*OUT_DIM` = 25 windows per frame.

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `pix_valid` in 1: pixel offered.
- `pix_data` in `PIX_W`: pixel, raster order, row-major.
- `pix_ready` out 1: pixel accepted when `pix_valid && pix_ready`.
- `w_valid` in 1: kernel byte offered.
- `w_data` in `PIX_W`: kernel byte, order k0..k8, row-major.
- `w_ready` out 1: kernel byte accepted when `w_valid && w_ready`.
- `in_valid` out 1: window valid, to the core.
- `In_IFM_1`..`In_IFM_9` out `PIX_W` each: window pixels, row-major.
- `weight_valid` out 1: kernel valid pulse, to the core.
- `In_Weight_1`..`In_Weight_9` out `PIX_W` each: kernel bytes k0..k8.
- `frame_done` out 1: one-cycle pulse on the last window.

## Operation
- Frame buffer: `IN_DIM` x `IN_DIM` registers. `IN_DIM` = `OUT_DIM`+2 = 7 by default (49 pixels). Weight shift register: 9 bytes. Both counters are 0-based.
- FSM states:
  - IDLE: `pix_ready`=1. The first pixel handshake moves to LOAD.
  - LOAD: `pix_ready`=1. When the last pixel is accepted, go to SEND if `w_loaded` is set or the 9th weight is accepted in the same cycle. Otherwise go to WAIT_W.
  - WAIT_W: `pix_ready`=0. Go to SEND on the cycle the 9th weight is accepted.
  - SEND: `pix_ready`=0. Lasts 25 cycles, with window index i = 0..24. After i=24, return to IDLE.
- Window i: r = i / `OUT_DIM`, c = i % `OUT_DIM`. `In_IFM_(3a+b+1)` = pix[(r+a)*`IN_DIM` + (c+b)], for a, b in 0..2.
- Weights:
  - `w_ready` = 1 in every state except SEND. Bytes arriving during SEND are back-pressured, so the core's kernel cannot change mid-frame.
  - A 4-bit counter counts 0..8. On the 9th accept, `weight_valid` pulses high for one cycle, all nine `In_Weight_n` update together, `w_loaded` is set, and the counter wraps to 0.
  - A new 9-byte kernel may be loaded between frames. It overwrites the old kernel and pulses `weight_valid` again.
- A pixel handshake and a weight handshake in the same cycle are both accepted.
- Outputs outside SEND: `In_IFM_n` hold the last window. `In_Weight_n` hold the last kernel.

## Timing
- All outputs are registered. `pix_ready` and `w_ready` are decoded from the state register.
- Reset values:
  - `in_valid`, `weight_valid`, `frame_done` = 0.
  - All `In_IFM_n` and `In_Weight_n` = 0.
  - `pix_ready` = 1 and `w_ready` = 1 (state IDLE).
  - Pixel count, weight count and `w_loaded` = 0.
- Latency, last pixel to first window: if the last pixel is accepted at cycle N with weights already loaded, `in_valid`=1 from N+1 to N+25 inclusive, with no gaps. `frame_done`=1 at N+25.
- Latency, 9th weight to kernel: if the 9th weight is accepted at cycle M, `weight_valid`=1 at M+1. When this coincides with the first window, both are asserted in the same cycle, and the core latches both.
- The next frame's first pixel is accepted no earlier than N+26.
- Reset mid-operation: on the clock where `rst_n`=0, all state returns to reset values. This includes a partial frame, a partial kernel and an in-progress SEND. `in_valid` drops at that edge.

## Configuration
- `CONV_FEEDER_PAD_EN` defined:
  - The input frame is `OUT_DIM`x`OUT_DIM` (25 pixels), and `IN_DIM` = `OUT_DIM`.
  - The window generator applies a one-pixel zero border: taps at row or column -1 or `OUT_DIM` read 0.
  - This gives "same" convolution and still produces 25 windows.
- Undefined: the frame is 7x7 (49 pixels) with no padding ("valid" convolution).
- FSM, handshakes and timing are identical in both builds. Only the frame size and tap addressing change.

## Test plan
- Kernel first, then frame: send k = 1..9, then pix[j] = j for j = 0..48. Expect `weight_valid` one cycle after k8. Expect 25 back-to-back `in_valid` cycles. Window 0 = {0,1,2,7,8,9,14,15,16}. Window 24 = {32,33,34,39,40,41,46,47,48}. `frame_done` with window 24.
- Frame before kernel: send 49 pixels, wait 10 idle cycles, then send 9 weights. Expect `pix_ready`=0 in WAIT_W. `weight_valid` and the first `in_valid` rise in the same cycle.
- Back-pressure: hold `w_valid`=1 with byte 0xAA throughout SEND. Expect `w_ready`=0 and `In_Weight_n` unchanged. Accepts resume the cycle after `frame_done`.
- Mid-frame reset: assert `rst_n`=0 for 1 cycle at window 10. Expect all outputs 0 and `pix_ready`=1. A full new frame then requires reloading 9 weights before any `in_valid`.
- Simultaneous events: the 49th pixel and the 9th weight are accepted in the same cycle. Expect `in_valid` and `weight_valid` both high the next cycle.
- `CONV_FEEDER_PAD_EN`: send a 5x5 frame of all 0xFF. Expect window 0 = {0,0,0,0,255,255,0,255,255} and window 12 = all 255.
